// File: rtl/hue_wheel.sv
// ---------------------------------------------------------------------------
// hue_wheel
//
// Duty-cycle sequencer for a continuous six-phase RGB colour wheel. It feeds
// three downstream PWM generators with a duty value (in PWM counts) per
// channel. A step timer advances a saturating ramp. Each time the ramp has
// held full scale for one step, the wheel moves to the next of six phases.
// The per-channel targets are a pure function of (phase, ramp). They are
// copied to the outputs only on a PWM frame boundary, so a PWM period never
// sees its duty change part-way through.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset; overrides every other input
//   run          1 = step timer advances; 0 = timer, ramp and phase hold
//   frame_start  one-cycle pulse at the start of each PWM period
//   duty_r/g/b   per-channel duty, 0..PWM_INTERVAL, updated on frame_start
//   duty_valid   one-cycle pulse in the cycle after duty_* load
//   phase        current wheel phase, 0..5
//   wrap         one-cycle pulse after the wheel goes from phase 5 to 0
// ---------------------------------------------------------------------------
module hue_wheel #(
    parameter int PWM_INTERVAL = 1200,   // PWM period in clk cycles = full-scale duty
    parameter int STEP_CYCLES  = 12000,  // clk cycles between ramp steps
    parameter int STEP_SIZE    = 12,     // duty increment per ramp step
    localparam int W = $clog2(PWM_INTERVAL + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         frame_start,
    output logic [W-1:0] duty_r,
    output logic [W-1:0] duty_g,
    output logic [W-1:0] duty_b,
    output logic         duty_valid,
    output logic [2:0]   phase,
    output logic         wrap
);

    // Timer width; keep at least one bit so a single-cycle step period still
    // elaborates.
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [W-1:0]  DUTY_MAX   = W'(PWM_INTERVAL);
    localparam logic [W-1:0]  DUTY_ZERO  = '0;
    localparam logic [W:0]    STEP_INC   = (W + 1)'(STEP_SIZE);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [2:0]    PHASE_LAST = 3'd5;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TW-1:0] timer;
    logic [W-1:0]  ramp;

    // -----------------------------------------------------------------------
    // Step decode and next-state logic
    // -----------------------------------------------------------------------
    logic          step;
    logic [TW-1:0] timer_next;
    logic [W:0]    ramp_sum;     // one bit wider so the saturation compare cannot wrap
    logic [W-1:0]  ramp_next;
    logic [2:0]    phase_next;
    logic          wrap_next;

    assign step     = run && (timer == TIMER_LAST);
    assign ramp_sum = {1'b0, ramp} + STEP_INC;

    always_comb begin
        // NOTE: every variable driven here is given a default first, so no
        // path through the block can leave one unassigned and infer a latch.
        timer_next = timer;
        if (run) begin
            if (timer == TIMER_LAST) begin
                timer_next = '0;
            end else begin
                timer_next = timer + TW'(1);
            end
        end
    end

    always_comb begin
        ramp_next  = ramp;
        phase_next = phase;
        wrap_next  = 1'b0;

        if (step) begin
            if (phase > PHASE_LAST) begin
                // Phases 6 and 7 are unreachable; recover to a clean start of
                // the wheel rather than decoding garbage targets indefinitely.
                phase_next = 3'd0;
                ramp_next  = DUTY_ZERO;
            end else if (ramp == DUTY_MAX) begin
                // Full scale has been held for one step: move to the next phase
                // and start its ramp from zero.
                ramp_next = DUTY_ZERO;
                if (phase == PHASE_LAST) begin
                    phase_next = 3'd0;
                    wrap_next  = 1'b1;
                end else begin
                    phase_next = phase + 3'd1;
                end
            end else if (ramp_sum > {1'b0, DUTY_MAX}) begin
                // Clamp the last partial step so the ramp lands exactly on
                // full scale instead of overshooting it.
                ramp_next = DUTY_MAX;
            end else begin
                ramp_next = ramp_sum[W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Target duties
    //
    // Each phase holds one channel at full scale, ramps a second one up or
    // down, and keeps the third at zero. The end of every phase equals the
    // start of the next, so the colour moves continuously around the wheel.
    // -----------------------------------------------------------------------
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] target_r;
    logic [W-1:0] target_g;
    logic [W-1:0] target_b;

    assign rise = ramp;
    assign fall = DUTY_MAX - ramp;

    always_comb begin
        target_r = DUTY_MAX;
        target_g = DUTY_ZERO;
        target_b = DUTY_ZERO;

        case (phase)
            3'd0: begin
                target_r = DUTY_MAX;
                target_g = rise;
                target_b = DUTY_ZERO;
            end
            3'd1: begin
                target_r = fall;
                target_g = DUTY_MAX;
                target_b = DUTY_ZERO;
            end
            3'd2: begin
                target_r = DUTY_ZERO;
                target_g = DUTY_MAX;
                target_b = rise;
            end
            3'd3: begin
                target_r = DUTY_ZERO;
                target_g = fall;
                target_b = DUTY_MAX;
            end
            3'd4: begin
                target_r = rise;
                target_g = DUTY_ZERO;
                target_b = DUTY_MAX;
            end
            3'd5: begin
                target_r = DUTY_MAX;
                target_g = DUTY_ZERO;
                target_b = fall;
            end
            default: begin
                // Unreachable phases show the phase-0 start colour until the
                // next step recovers the wheel.
                target_r = DUTY_MAX;
                target_g = DUTY_ZERO;
                target_b = DUTY_ZERO;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    //
    // The duty outputs sample the targets computed from the current (pre-step)
    // ramp and phase. A step and a frame_start on the same edge therefore load
    // the old targets; the new ones reach the outputs on the next frame_start.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs as they were before this edge.
        if (!rst_n) begin
            timer      <= '0;
            ramp       <= DUTY_ZERO;
            phase      <= 3'd0;
            wrap       <= 1'b0;
            duty_r     <= DUTY_MAX;
            duty_g     <= DUTY_ZERO;
            duty_b     <= DUTY_ZERO;
            duty_valid <= 1'b0;
        end else begin
            timer      <= timer_next;
            ramp       <= ramp_next;
            phase      <= phase_next;
            wrap       <= wrap_next;
            duty_valid <= frame_start;
            if (frame_start) begin
                duty_r <= target_r;
                duty_g <= target_g;
                duty_b <= target_b;
            end
        end
    end

endmodule

// File: tb/tb_hue_wheel.sv
// ---------------------------------------------------------------------------
// tb_hue_wheel
//
// Directed bench for hue_wheel. The main instance uses a small configuration
// (PWM_INTERVAL=10, STEP_CYCLES=4, STEP_SIZE=3) so that whole phases and a
// whole wheel fit into a few hundred cycles. A second instance with the
// default configuration is used only to confirm the full-scale reset values.
//
// Edge numbering in the comments: "edge k" is the k-th rising clock edge
// after rst_n is released. The timer is 0 after reset, so with run=1 the
// steps land on edges 4, 8, 12, ... and each phase spans 20 edges.
// Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hue_wheel;

    localparam int PI     = 10;
    localparam int SC     = 4;
    localparam int SS     = 3;
    localparam int W      = $clog2(PI + 1);
    localparam int BIG_PI = 1200;
    localparam int BIG_W  = $clog2(BIG_PI + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic frame_start;

    logic [W-1:0] duty_r;
    logic [W-1:0] duty_g;
    logic [W-1:0] duty_b;
    logic         duty_valid;
    logic [2:0]   phase;
    logic         wrap;

    logic [BIG_W-1:0] big_duty_r;
    logic [BIG_W-1:0] big_duty_g;
    logic [BIG_W-1:0] big_duty_b;
    logic             big_duty_valid;
    logic [2:0]       big_phase;
    logic             big_wrap;

    int total = 0;
    int bad   = 0;

    hue_wheel #(
        .PWM_INTERVAL (PI),
        .STEP_CYCLES  (SC),
        .STEP_SIZE    (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .frame_start (frame_start),
        .duty_r      (duty_r),
        .duty_g      (duty_g),
        .duty_b      (duty_b),
        .duty_valid  (duty_valid),
        .phase       (phase),
        .wrap        (wrap)
    );

    hue_wheel dut_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .frame_start (frame_start),
        .duty_r      (big_duty_r),
        .duty_g      (big_duty_g),
        .duty_b      (big_duty_b),
        .duty_valid  (big_duty_valid),
        .phase       (big_phase),
        .wrap        (big_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [3*W-1:0] pack(input int r, input int g, input int b);
        return {W'(r), W'(g), W'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three reset edges with all other inputs idle, then release.
    task automatic do_reset();
        rst_n       = 1'b0;
        run         = 1'b0;
        frame_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        // Values right after the reset edges (rst_n just released, no edge yet).
        total++;
        if ({duty_r, duty_g, duty_b} !== pack(PI, 0, 0)) begin
            bad++;
            $display("FAIL reset_duty got=%h want=%h", {duty_r, duty_g, duty_b}, pack(PI, 0, 0));
        end
        total++;
        if (phase !== 3'd0 || duty_valid !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got phase=%0d valid=%b wrap=%b want 0/0/0",
                     phase, duty_valid, wrap);
        end
        total++;
        if (big_duty_r !== BIG_W'(BIG_PI) || big_duty_g !== '0 || big_duty_b !== '0) begin
            bad++;
            $display("FAIL reset_big_duty got=%0d,%0d,%0d want=1200,0,0",
                     big_duty_r, big_duty_g, big_duty_b);
        end
        total++;
        if (big_phase !== 3'd0 || big_duty_valid !== 1'b0 || big_wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_big_ctrl got phase=%0d valid=%b wrap=%b want 0/0/0",
                     big_phase, big_duty_valid, big_wrap);
        end
        // With run=0 and no frame_start, one more edge must change nothing.
        tick();
        total++;
        if ({duty_r, duty_g, duty_b} !== pack(PI, 0, 0) || phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle got=%h phase=%0d want=%h phase=0",
                     {duty_r, duty_g, duty_b}, phase, pack(PI, 0, 0));
        end
    endtask

    // -----------------------------------------------------------------------
    // frame_start tied high: duty after edge k shows the target from before
    // edge k. Ramp is 0,3,6,9,10 after edges 0,4,8,12,16; phase 1 at edge 20.
    task automatic test_ramp();
        logic [3*W-1:0] want;
        logic           chk;
        do_reset();
        run         = 1'b1;
        frame_start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk  = 1'b1;
            want = '0;
            case (k)
                1:       want = pack(PI, 0, 0);
                4:       want = pack(PI, 0, 0);   // step edge loads the old target
                5:       want = pack(PI, 3, 0);
                9:       want = pack(PI, 6, 0);
                13:      want = pack(PI, 9, 0);
                17:      want = pack(PI, 10, 0);  // saturated at 10, not 12
                20:      want = pack(PI, 10, 0);  // full scale held for one step
                21:      want = pack(10, PI, 0);  // phase 1, ramp 0: fall=10
                25:      want = pack(7, PI, 0);   // phase 1, ramp 3
                default: chk = 1'b0;
            endcase
            if (chk) begin
                total++;
                if ({duty_r, duty_g, duty_b} !== want) begin
                    bad++;
                    $display("FAIL ramp_duty k=%0d got=%h want=%h", k, {duty_r, duty_g, duty_b}, want);
                end
            end
            if (k == 1) begin
                total++;
                if (duty_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL ramp_valid got=%b want=1", duty_valid);
                end
            end
            if (k == 19 || k == 20) begin
                total++;
                if (phase !== ((k == 20) ? 3'd1 : 3'd0)) begin
                    bad++;
                    $display("FAIL ramp_phase k=%0d got=%0d want=%0d", k, phase, (k == 20) ? 1 : 0);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Two whole wheels: wrap after edges 120 and 240 only, phase p after edge
    // 20p, and the start-of-phase colour one edge later.
    task automatic test_full_wheel();
        logic [3*W-1:0] starts [6];
        logic           want_wrap;
        starts[0] = pack(10, 0, 0);
        starts[1] = pack(10, 10, 0);
        starts[2] = pack(0, 10, 0);
        starts[3] = pack(0, 10, 10);
        starts[4] = pack(0, 0, 10);
        starts[5] = pack(10, 0, 10);
        do_reset();
        run         = 1'b1;
        frame_start = 1'b1;
        for (int k = 1; k <= 241; k++) begin
            tick();
            want_wrap = (k == 120 || k == 240);
            total++;
            if (wrap !== want_wrap) begin
                bad++;
                $display("FAIL wheel_wrap k=%0d got=%b want=%b", k, wrap, want_wrap);
            end
            if (k % 20 == 0) begin
                total++;
                if (phase !== 3'((k / 20) % 6)) begin
                    bad++;
                    $display("FAIL wheel_phase k=%0d got=%0d want=%0d", k, phase, (k / 20) % 6);
                end
            end
            if (k % 20 == 1 && k <= 121) begin
                total++;
                if ({duty_r, duty_g, duty_b} !== starts[((k - 1) / 20) % 6]) begin
                    bad++;
                    $display("FAIL wheel_start k=%0d got=%h want=%h", k,
                             {duty_r, duty_g, duty_b}, starts[((k - 1) / 20) % 6]);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // frame_start on edges 7,14,21,28,35. Edge 28 is also a step edge, so it
    // loads the pre-step target (phase 1, ramp 3). Edge 35 shows the targets
    // after the steps at 28 and 32 (phase 1, ramp 9).
    task automatic test_frame_gating();
        logic [3*W-1:0] frames [1:5];
        logic [3*W-1:0] want;
        logic           want_valid;
        frames[1] = pack(10, 3, 0);
        frames[2] = pack(10, 9, 0);
        frames[3] = pack(10, 10, 0);
        frames[4] = pack(7, 10, 0);
        frames[5] = pack(1, 10, 0);
        want = pack(PI, 0, 0);
        do_reset();
        run         = 1'b1;
        frame_start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            frame_start = ((k + 1) % 7 == 0);
            if (k % 7 == 0) want = frames[k / 7];
            want_valid = (k % 7 == 0);
            total++;
            if ({duty_r, duty_g, duty_b} !== want) begin
                bad++;
                $display("FAIL frame_duty k=%0d got=%h want=%h", k, {duty_r, duty_g, duty_b}, want);
            end
            total++;
            if (duty_valid !== want_valid) begin
                bad++;
                $display("FAIL frame_valid k=%0d got=%b want=%b", k, duty_valid, want_valid);
            end
        end
        frame_start = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // After edge 14: timer=2, ramp=9. Hold run low for 20 edges, then the
    // step must land on the 2nd edge after run returns (ramp 10), visible on
    // duty_g one edge later.
    task automatic test_run_hold();
        do_reset();
        run         = 1'b1;
        frame_start = 1'b1;
        repeat (14) tick();
        run = 1'b0;
        repeat (20) tick();
        total++;
        if (duty_g !== W'(9) || phase !== 3'd0) begin
            bad++;
            $display("FAIL hold_frozen got g=%0d phase=%0d want g=9 phase=0", duty_g, phase);
        end
        run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (duty_g !== ((k == 3) ? W'(10) : W'(9))) begin
                bad++;
                $display("FAIL hold_resume k=%0d got g=%0d want g=%0d", k, duty_g, (k == 3) ? 10 : 9);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Reset during phase 3 with ramp=6 (after edge 69, timer=1). One reset
    // edge restores everything even with run and frame_start high; the next
    // step comes STEP_CYCLES edges after release.
    task automatic test_reset_mid();
        do_reset();
        run         = 1'b1;
        frame_start = 1'b1;
        repeat (69) tick();
        total++;
        if (phase !== 3'd3 || {duty_r, duty_g, duty_b} !== pack(0, 4, 10)) begin
            bad++;
            $display("FAIL mid_before got phase=%0d duty=%h want phase=3 duty=%h",
                     phase, {duty_r, duty_g, duty_b}, pack(0, 4, 10));
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({duty_r, duty_g, duty_b} !== pack(PI, 0, 0) || phase !== 3'd0
            || duty_valid !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got duty=%h phase=%0d valid=%b wrap=%b want duty=%h 0/0/0",
                     {duty_r, duty_g, duty_b}, phase, duty_valid, wrap, pack(PI, 0, 0));
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 3) begin
                total++;
                if (duty_g !== ((k == 5) ? W'(3) : W'(0)) || phase !== 3'd0) begin
                    bad++;
                    $display("FAIL mid_restart k=%0d got g=%0d phase=%0d want g=%0d phase=0",
                             k, duty_g, phase, (k == 5) ? 3 : 0);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        frame_start = 1'b0;
        test_reset();
        test_ramp();
        test_full_wheel();
        test_frame_gating();
        test_run_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
